iob_dev: RTL and testbench
==========================

// Module: iob_dev
// PURPOSE
// - Responder on the KA10 I/O bus: a generic buffered peripheral. It decodes the
//   device select and the DATAO/DATAI/CONO/CONI strobes and raises PI requests.
// - Output side: a DATAO word is shifted out to a sink after a fixed transfer time.
// - Input side: a word from an external source is held until the CPU reads it with DATAI.
// - Instanced in pdp10 beside ka10. Its iobus_iob_out is ORed into the CPU's iob_in,
//   and its pi is ORed into iobus_pi.
// PARAMETERS
// - DEVNO      7'o044  device number, compared with iobus_ios[3:9]
// - XFER_CYC   16      clk cycles from DATAO to done (>=1)
// PORTS
// - clk                input   1   system clock
// - reset              input   1   synchronous, active-high
// - iobus_iob_reset    input   1   bus reset (level), same effect as reset
// - iobus_ios          input   7   [3:9] device select
// - iobus_datao_clear  input   1   DATAO clear pulse
// - iobus_datao_set    input   1   DATAO set pulse
// - iobus_cono_clear   input   1   CONO clear pulse
// - iobus_cono_set     input   1   CONO set pulse
// - iobus_iob_datai    input   1   DATAI level
// - iobus_iob_coni     input   1   CONI level
// - iobus_iob_in       input   36  [0:35] data from CPU (CPU iob_out)
// - iobus_iob_out      output  36  [0:35] data to CPU; 0 unless selected and reading
// - iobus_pi           output  7   [1:7] PI request lines
// - ext_in_valid       input   1   one-cycle strobe, ext_in_data valid
// - ext_in_data        input   36  word from external source
// - ext_out_strobe     output  1   one-cycle pulse: ext_out_data valid
// - ext_out_data       output  36  transmitted word
// BEHAVIOUR
// - Reset and bus reset:
//   - All state clears: dbuf_o, dbuf_i, PIA, done, busy, in_full, overrun, timer.
//   - Outputs go to 0. ext_out_data holds its last value; its reset value is 0.
// - sel = (iobus_ios == DEVNO). Every strobe is ignored unless sel is high.
// - Status word (CONI):
//   - bit 29 overrun, bit 30 in_full, bit 31 busy, bit 32 done, bits 33:35 PIA.
//   - All other bits are 0.
// - CONO:
//   - cono_clear clears PIA, done, busy, overrun and the timer.
//   - cono_set ORs iob_in[33:35] into PIA.
//   - cono_set with iob_in[32]=1 sets done; with iob_in[29]=1 it clears overrun.
// - DATAO:
//   - datao_clear zeroes dbuf_o and clears done.
//   - datao_set ORs iob_in into dbuf_o, sets busy and loads the timer with XFER_CYC.
//   - datao_set while busy: the OR still applies and the timer restarts.
// - Timer:
//   - It decrements each cycle while busy.
//   - On the cycle it reaches 0: busy->0, done->1, ext_out_strobe=1 for one cycle,
//     ext_out_data<=dbuf_o.
//   - If cono_clear or datao_clear lands in the expiry cycle, the clear wins and no
//     strobe is issued.
// - DATAI:
//   - While iob_datai and sel are high, iobus_iob_out = dbuf_i (combinational).
//   - in_full clears on the cycle after iob_datai falls (registered edge detect).
// - CONI: while iob_coni and sel are high, iobus_iob_out = status (combinational).
// - Input side:
//   - ext_in_valid with in_full=0 loads dbuf_i and sets in_full.
//   - ext_in_valid with in_full=1 sets overrun; dbuf_i is unchanged.
//   - ext_in_valid in the same cycle as the DATAI falling-edge clear: load happens,
//     in_full stays 1, no overrun.
// - PI: iobus_pi[n] = (PIA==n) & (done | in_full), for n=1..7. PIA=0 requests nothing.
// - Latency:
//   - Register effects of a strobe are visible on the next clk edge.
//   - Bus read data is zero-latency.
// STRUCTURE
// - Package iob_pkg holds:
//   - status bit index constants: ST_OVR=29, ST_INF=30, ST_BSY=31, ST_DON=32, ST_PIA=33.
//   - a function pi_decode(pia) -> [1:7] one-hot.
//   - the 36-bit word type.
// - Sub-module iob_xfer_timer holds the load/decrement/expire counter. Its ports:
//   - inputs: clk, reset, load, abort.
//   - outputs: busy, expire (one-cycle pulse).
// - The top level holds the select decode, registers and read mux.
// TESTING
// - Device select:
//   - Action: DEVNO=7'o044, ios=7'o043, cono_set with iob_in=36'o7.
//   - Required: PIA stays 0, iob_out=0 during CONI.
// - CONO and CONI:
//   - Action: cono_set with iob_in=36'o000000_000003, then CONI.
//   - Required: iob_out=36'o3, pi=7'b0000000.
//   - Action: then cono_set with bit 32 set.
//   - Required: pi[3]=1.
// - DATAO and transfer:
//   - Action: datao_clear, then datao_set with 36'o123456_111222.
//   - Required: busy=1; after exactly 16 cycles ext_out_strobe=1,
//     ext_out_data=36'o123456111222, done=1.
// - Abort:
//   - Action: datao_set, then cono_clear 5 cycles later.
//   - Required: busy=0, no ext_out_strobe ever, done=0.
// - Input path:
//   - Action: ext_in_valid 36'o777776_000111; DATAI for 3 cycles.
//   - Required: iob_out=36'o777776000111 during DATAI; in_full=0 one cycle after DATAI drops.
//   - Action: a second ext_in_valid before that DATAI.
//   - Required: CONI bit 29 =1.
// - Reset mid-transfer:
//   - Action: reset pulse 3 cycles after datao_set.
//   - Required: all status 0, pi=0, no strobe. Repeat the same check with iobus_iob_reset.

Source files
------------

// File: rtl/iob_pkg.sv
// Shared types and constants for the KA10 I/O bus buffered peripheral.
// Bit numbers follow the PDP-10 convention: bit 0 is the MSB, bit 35 the LSB.
package iob_pkg;

    typedef logic [0:35] word_t;

    localparam int ST_OVR = 29;
    localparam int ST_INF = 30;
    localparam int ST_BSY = 31;
    localparam int ST_DON = 32;
    localparam int ST_PIA = 33;

    function automatic logic [1:7] pi_decode(input logic [2:0] pia);
        logic [1:7] r;
        r = '0;
        for (int n = 1; n <= 7; n++) begin
            r[n] = (pia == 3'(n));
        end
        return r;
    endfunction

endpackage

// File: rtl/iob_xfer_timer.sv
// Transfer timer: load starts a XFER_CYC countdown, abort cancels it,
// expire pulses on the cycle the count steps from 1 to 0.
module iob_xfer_timer #(
    parameter int XFER_CYC = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic abort,
    output logic busy,
    output logic expire
);

    localparam int CW = $clog2(XFER_CYC + 1);

    logic [CW-1:0] count;

    assign busy   = (count != '0);
    // A reload or abort in the final cycle suppresses the expiry.
    assign expire = busy && (count == CW'(1)) && !abort && !load;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= CW'(XFER_CYC);
        end else if (abort) begin
            count <= '0;
        end else if (busy) begin
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/iob_dev.sv
// Generic buffered I/O bus responder: DATAO word shifted to a sink after a
// fixed transfer time, external input word held for DATAI, PI on done/in_full.
module iob_dev
    import iob_pkg::*;
#(
    parameter logic [6:0] DEVNO    = 7'o044,
    parameter int         XFER_CYC = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iobus_iob_reset,
    input  logic [3:9]  iobus_ios,
    input  logic        iobus_datao_clear,
    input  logic        iobus_datao_set,
    input  logic        iobus_cono_clear,
    input  logic        iobus_cono_set,
    input  logic        iobus_iob_datai,
    input  logic        iobus_iob_coni,
    input  logic [0:35] iobus_iob_in,
    output logic [0:35] iobus_iob_out,
    output logic [1:7]  iobus_pi,
    input  logic        ext_in_valid,
    input  logic [0:35] ext_in_data,
    output logic        ext_out_strobe,
    output logic [0:35] ext_out_data
);

    word_t      dbuf_o;
    word_t      dbuf_i;
    word_t      status;
    word_t      out_data;
    logic [2:0] pia;
    logic       done;
    logic       in_full;
    logic       overrun;
    logic       datai_q;
    logic       strobe;
    logic       busy;
    logic       expire;

    logic rst;
    logic sel;
    logic cono_clr;
    logic cono_st;
    logic datao_clr;
    logic datao_st;
    logic datai_sel;
    logic coni_sel;
    logic datai_fall;
    logic fire;
    logic in_load;
    logic ovr_set;

    assign rst        = reset | iobus_iob_reset;
    assign sel        = (iobus_ios == DEVNO);
    assign cono_clr   = sel & iobus_cono_clear;
    assign cono_st    = sel & iobus_cono_set;
    assign datao_clr  = sel & iobus_datao_clear;
    assign datao_st   = sel & iobus_datao_set;
    assign datai_sel  = sel & iobus_iob_datai;
    assign coni_sel   = sel & iobus_iob_coni;
    assign datai_fall = datai_q & ~datai_sel;

    // datao_clear only cancels a transfer that would complete this cycle.
    assign fire    = expire & ~datao_clr;
    assign in_load = ext_in_valid & (~in_full | datai_fall);
    assign ovr_set = ext_in_valid & in_full & ~datai_fall;

    iob_xfer_timer #(
        .XFER_CYC(XFER_CYC)
    ) u_timer (
        .clk   (clk),
        .reset (rst),
        .load  (datao_st),
        .abort (cono_clr),
        .busy  (busy),
        .expire(expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            dbuf_o   <= '0;
            dbuf_i   <= '0;
            out_data <= '0;
            pia      <= '0;
            done     <= 1'b0;
            in_full  <= 1'b0;
            overrun  <= 1'b0;
            datai_q  <= 1'b0;
            strobe   <= 1'b0;
        end else begin
            datai_q <= datai_sel;
            strobe  <= fire;
            if (fire) begin
                out_data <= dbuf_o;
            end
            dbuf_o <= (datao_clr ? '0 : dbuf_o)
                    | (datao_st ? iobus_iob_in : '0);
            pia <= (cono_clr ? 3'b000 : pia)
                 | (cono_st ? iobus_iob_in[ST_PIA +: 3] : 3'b000);
            if (cono_st && iobus_iob_in[ST_DON]) begin
                done <= 1'b1;
            end else if (cono_clr || datao_clr) begin
                done <= 1'b0;
            end else if (fire) begin
                done <= 1'b1;
            end
            if (cono_clr || (cono_st && iobus_iob_in[ST_OVR])) begin
                overrun <= 1'b0;
            end else if (ovr_set) begin
                overrun <= 1'b1;
            end
            if (in_load) begin
                dbuf_i  <= ext_in_data;
                in_full <= 1'b1;
            end else if (datai_fall) begin
                in_full <= 1'b0;
            end
        end
    end

    always_comb begin
        status                = '0;
        status[ST_OVR]        = overrun;
        status[ST_INF]        = in_full;
        status[ST_BSY]        = busy;
        status[ST_DON]        = done;
        status[ST_PIA +: 3]   = pia;
    end

    assign iobus_iob_out = ({36{datai_sel}} & dbuf_i)
                         | ({36{coni_sel}} & status);
    assign iobus_pi       = pi_decode(pia) & {7{done | in_full}};
    assign ext_out_strobe = strobe;
    assign ext_out_data   = out_data;

endmodule

// File: tb/tb_iob_dev.sv
// Scoreboard bench for iob_dev: directed scenarios then random traffic,
// checked against a transaction-level model of the device registers.
module tb_iob_dev;
    import iob_pkg::*;

    localparam logic [6:0] DEV  = 7'o044;
    localparam int         XFER = 16;

    localparam int K_IDLE = 0;
    localparam int K_CC   = 1;
    localparam int K_CS   = 2;
    localparam int K_DC   = 3;
    localparam int K_DS   = 4;
    localparam int K_EXT  = 5;
    localparam int K_DI   = 6;
    localparam int K_CI   = 7;
    localparam int K_RST  = 8;
    localparam int K_BRST = 9;

    typedef struct {
        logic [0:35] w;
        int          c;
    } xfer_t;

    typedef struct {
        logic [0:35] o;
        logic [1:7]  p;
        int          c;
    } rd_t;

    logic        clk;
    logic        reset;
    logic        iob_reset;
    logic [3:9]  ios;
    logic        datao_clear;
    logic        datao_set;
    logic        cono_clear;
    logic        cono_set;
    logic        datai;
    logic        coni;
    logic [0:35] iob_in;
    logic [0:35] iob_out;
    logic [1:7]  pi;
    logic        ext_valid;
    logic [0:35] ext_data;
    logic        out_strobe;
    logic [0:35] out_data;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    xfer_t out_q[$];
    rd_t   rd_q[$];

    // reference model state
    bit          m_valid;
    logic [2:0]  m_pia;
    bit          m_done;
    bit          m_busy;
    int          m_deadline;
    bit          m_inf;
    bit          m_ovr;
    bit          m_prev_rd;
    logic [0:35] m_dbo;
    logic [0:35] m_dbi;

    iob_dev #(
        .DEVNO   (DEV),
        .XFER_CYC(XFER)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .iobus_iob_reset  (iob_reset),
        .iobus_ios        (ios),
        .iobus_datao_clear(datao_clear),
        .iobus_datao_set  (datao_set),
        .iobus_cono_clear (cono_clear),
        .iobus_cono_set   (cono_set),
        .iobus_iob_datai  (datai),
        .iobus_iob_coni   (coni),
        .iobus_iob_in     (iob_in),
        .iobus_iob_out    (iob_out),
        .iobus_pi         (pi),
        .ext_in_valid     (ext_valid),
        .ext_in_data      (ext_data),
        .ext_out_strobe   (out_strobe),
        .ext_out_data     (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [0:35] rnd36();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[35:0];
    endfunction

    function automatic logic [0:35] m_status();
        logic [0:35] s;
        s        = '0;
        s[29]    = m_ovr;
        s[30]    = m_inf;
        s[31]    = m_busy;
        s[32]    = m_done;
        s[33:35] = m_pia;
        return s;
    endfunction

    function automatic logic [1:7] m_pi();
        logic [1:7] p;
        for (int n = 1; n <= 7; n++) begin
            p[n] = (m_pia == 3'(n)) && (m_done || m_inf);
        end
        return p;
    endfunction

    task automatic model_edge();
        bit s, rd, cc, cs, dc, ds, expiring, fire, fall;
        s  = (ios == DEV);
        rd = s && datai;
        if (reset || iob_reset) begin
            m_valid   = 1;
            m_pia     = '0;
            m_done    = 0;
            m_busy    = 0;
            m_inf     = 0;
            m_ovr     = 0;
            m_prev_rd = 0;
            m_dbo     = '0;
            m_dbi     = '0;
            return;
        end
        cc = s && cono_clear;
        cs = s && cono_set;
        dc = s && datao_clear;
        ds = s && datao_set;
        expiring = m_busy && (cyc == m_deadline);
        fire = expiring && !cc && !dc && !ds;
        if (fire) out_q.push_back('{w: m_dbo, c: cyc});
        if (expiring || cc) m_busy = 0;
        if (ds) begin
            m_busy     = 1;
            m_deadline = cyc + XFER;
        end
        if (fire) m_done = 1;
        if (cc || dc) m_done = 0;
        if (cs && iob_in[32]) m_done = 1;
        if (cc) m_pia = '0;
        if (cs) m_pia = m_pia | iob_in[33:35];
        if (dc) m_dbo = '0;
        if (ds) m_dbo = m_dbo | iob_in;
        fall = m_prev_rd && !rd;
        m_prev_rd = rd;
        if (ext_valid && (!m_inf || fall)) begin
            m_dbi = ext_data;
            m_inf = 1;
        end else if (ext_valid) begin
            m_ovr = 1;
        end else if (fall) begin
            m_inf = 0;
        end
        if (cc || (cs && iob_in[29])) m_ovr = 0;
    endtask

    task automatic tick();
        logic [0:35] e;
        bit s;
        if (m_valid) begin
            s = (ios == DEV);
            e = '0;
            if (s && datai) e = e | m_dbi;
            if (s && coni)  e = e | m_status();
            rd_q.push_back('{o: e, p: m_pi(), c: cyc});
        end
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
    endtask

    task automatic clear_all();
        reset       = 0;
        iob_reset   = 0;
        datao_clear = 0;
        datao_set   = 0;
        cono_clear  = 0;
        cono_set    = 0;
        coni        = 0;
        ext_valid   = 0;
    endtask

    task automatic op(input int k, input logic [0:35] d);
        iob_in = d;
        case (k)
            K_CC:   cono_clear  = 1;
            K_CS:   cono_set    = 1;
            K_DC:   datao_clear = 1;
            K_DS:   datao_set   = 1;
            K_EXT: begin
                ext_valid = 1;
                ext_data  = d;
            end
            K_DI:   datai       = 1;
            K_CI:   coni        = 1;
            K_RST:  reset       = 1;
            K_BRST: iob_reset   = 1;
            default: ;
        endcase
        tick();
        clear_all();
        datai = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            coni = ((i % 4) == 1);
            tick();
            coni = 0;
        end
    endtask

    always @(negedge clk) begin
        rd_t   r;
        xfer_t x;
        if (rd_q.size() > 0) begin
            r = rd_q.pop_front();
            n_cmp++;
            if (iob_out !== r.o || pi !== r.p) begin
                n_err++;
                $display("FAIL read cyc=%0d got out=%012o pi=%b want out=%012o pi=%b",
                         r.c, iob_out, pi, r.o, r.p);
            end
        end
        while (out_q.size() > 0 && out_q[0].c < cyc) begin
            x = out_q.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL strobe_missing cyc=%0d got none want %012o", x.c, x.w);
        end
        if (m_valid && out_strobe !== 1'b0) begin
            n_cmp++;
            if (out_q.size() == 0 || out_q[0].c != cyc) begin
                n_err++;
                $display("FAIL strobe_unexpected cyc=%0d got %012o want no strobe",
                         cyc, out_data);
            end else begin
                x = out_q.pop_front();
                if (out_data !== x.w) begin
                    n_err++;
                    $display("FAIL strobe_data cyc=%0d got %012o want %012o",
                             cyc, out_data, x.w);
                end
            end
        end
    end

    initial begin
        m_valid = 0;
        ios     = DEV;
        datai   = 0;
        iob_in  = '0;
        ext_data = '0;
        clear_all();
        op(K_RST, '0);
        op(K_RST, '0);
        idle(2);

        // device select: wrong ios ignores CONO and reads zero
        ios = 7'o043;
        op(K_CS, 36'o7);
        op(K_CI, '0);
        ios = DEV;
        op(K_CI, '0);

        // CONO / CONI and PI
        op(K_CS, 36'o000000_000003);
        op(K_CI, '0);
        op(K_CS, 36'o000000_000010);
        op(K_CI, '0);

        // DATAO transfer
        op(K_DC, '0);
        op(K_DS, 36'o123456_111222);
        op(K_CI, '0);
        idle(20);
        op(K_CI, '0);

        // abort mid transfer
        op(K_DS, 36'o000777_000000);
        idle(4);
        op(K_CC, '0);
        idle(20);
        op(K_CI, '0);

        // input path with overrun
        op(K_EXT, 36'o777776_000111);
        op(K_EXT, 36'o000001_000002);
        op(K_CI, '0);
        datai = 1;
        tick();
        tick();
        tick();
        datai = 0;
        op(K_CI, '0);
        op(K_CI, '0);

        // reset and bus reset mid transfer
        op(K_CS, 36'o000000_000005);
        op(K_DS, 36'o525252_525252);
        idle(2);
        op(K_RST, '0);
        idle(20);
        op(K_CI, '0);
        op(K_CS, 36'o000000_000002);
        op(K_EXT, 36'o1);
        op(K_DS, 36'o252525_252525);
        idle(2);
        op(K_BRST, '0);
        idle(20);
        op(K_CI, '0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            int r;
            ios = ($urandom_range(0, 9) == 0) ? 7'o043 : DEV;
            iob_in = rnd36();
            r = $urandom_range(0, 99);
            if (r < 3)       datao_set   = 1;
            else if (r < 5)  datao_clear = 1;
            else if (r < 7)  cono_clear  = 1;
            else if (r < 11) cono_set    = 1;
            else if (r < 30) coni        = 1;
            if ($urandom_range(0, 9) == 0) begin
                ext_valid = 1;
                ext_data  = rnd36();
            end
            if ($urandom_range(0, 5) == 0) datai = ~datai;
            if ($urandom_range(0, 299) == 0) begin
                if ($urandom_range(0, 1) == 0) reset = 1;
                else iob_reset = 1;
            end
            tick();
            clear_all();
        end
        datai = 0;
        ios   = DEV;
        idle(XFER + 8);

        n_cmp++;
        if (out_q.size() != 0) begin
            n_err++;
            $display("FAIL drain got %0d pending strobes want 0", out_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
